debug_net_inject_ctrl: RTL and testbench

- Schedules 32-bit words into the CPU network input port of the debug SoC.
- Arbitrates round-robin between two requesters:
  - A: an Avalon-MM debug host, which writes into an internal FIFO.
  - B: a hardware requester with a valid/ready interface.
- The winner loads a registered output stage that drives a valid/ready network port.
- Provides status and a sent-word counter for host polling.

---
 rtl/debug_net_inject_ctrl_if.sv | 29 ++
 rtl/debug_net_inject_ctrl.sv | 141 ++++++++++++++
 tb/tb_debug_net_inject_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/debug_net_inject_ctrl_if.sv
`default_nettype none
// ==========================================================================
// debug_net_inject_ctrl_if : Avalon host, hardware requester and network port
// Revision : 1.0
// ==========================================================================
interface debug_net_inject_ctrl_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        hw_valid;
    logic [31:0] hw_data;
    logic        hw_ready;
    logic        net_valid;
    logic [31:0] net_data;
    logic        net_ready;

    modport slave (
        input  address, chipselect, write_n, writedata, hw_valid, hw_data, net_ready,
        output readdata, hw_ready, net_valid, net_data
    );

    modport master (
        output address, chipselect, write_n, writedata, hw_valid, hw_data, net_ready,
        input  readdata, hw_ready, net_valid, net_data
    );
endinterface
`default_nettype wire

// File: rtl/debug_net_inject_ctrl.sv
`default_nettype none
// ==========================================================================
// debug_net_inject_ctrl : round-robin host-FIFO / hardware word injector
// Revision : 1.0
// ==========================================================================
module debug_net_inject_ctrl #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CNT_W      = 8
) (
    input  wire logic               clk,
    input  wire logic               reset_n,
    debug_net_inject_ctrl_if.slave  bus
);

    localparam int unsigned c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int unsigned c_cnt_w = c_ptr_w + 1;

    logic [31:0]        mem_q [FIFO_DEPTH];
    logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_cnt_w-1:0] count_q, count_d;
    logic               enable_q, enable_d;
    logic               overflow_q, overflow_d;
    logic               net_valid_q, net_valid_d;
    logic [31:0]        net_data_q, net_data_d;
    logic               last_grant_q, last_grant_d;
    logic [31:0]        tx_count_q, tx_count_d;

    logic        wr_en, data_wr, ctrl_wr, flush, clr_ovf;
    logic        fifo_empty, fifo_full, load;
    logic        req_a, req_b, win_b, hw_ready, push, pop, ovf_set;
    logic [31:0] status;

    always_comb begin
        wr_en      = bus.chipselect && !bus.write_n;
        data_wr    = wr_en && (bus.address == 2'd0);
        ctrl_wr    = wr_en && (bus.address == 2'd2);
        flush      = ctrl_wr && bus.writedata[1];
        clr_ovf    = ctrl_wr && bus.writedata[2];
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == c_cnt_w'(FIFO_DEPTH));
        load       = enable_q && (!net_valid_q || bus.net_ready);
        // A flush hides the FIFO from arbitration so nothing is popped that cycle.
        req_a      = !fifo_empty && !flush;
        req_b      = bus.hw_valid;
        win_b      = req_b && (!req_a || !last_grant_q);
        hw_ready   = load && win_b;
        pop        = load && req_a && !win_b;
        push       = data_wr && !flush && !fifo_full;
        ovf_set    = data_wr && !flush && fifo_full;

        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        enable_d     = enable_q;
        overflow_d   = overflow_q;
        net_valid_d  = net_valid_q;
        net_data_d   = net_data_q;
        last_grant_d = last_grant_q;
        tx_count_d   = tx_count_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
        end

        if (ctrl_wr) enable_d = bus.writedata[0];

        if (clr_ovf) overflow_d = 1'b0;
        if (ovf_set) overflow_d = 1'b1;

        if (load && (req_a || req_b)) begin
            net_data_d   = win_b ? bus.hw_data : mem_q[rd_ptr_q];
            net_valid_d  = 1'b1;
            last_grant_d = win_b;
        end else if (load && bus.net_ready) begin
            net_valid_d = 1'b0;
        end

        if (net_valid_q && bus.net_ready) tx_count_d = tx_count_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            enable_q     <= 1'b0;
            overflow_q   <= 1'b0;
            net_valid_q  <= 1'b0;
            net_data_q   <= '0;
            last_grant_q <= 1'b1;
            tx_count_q   <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            enable_q     <= enable_d;
            overflow_q   <= overflow_d;
            net_valid_q  <= net_valid_d;
            net_data_q   <= net_data_d;
            last_grant_q <= last_grant_d;
            tx_count_q   <= tx_count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.writedata;
    end

    always_comb begin
        status        = '0;
        status[0]     = fifo_empty;
        status[1]     = fifo_full;
        status[2]     = overflow_q;
        status[3]     = net_valid_q;
        status[4]     = last_grant_q;
        status[15:8]  = 8'(CNT_W'(count_q));
        status[16]    = enable_q;

        case (bus.address)
            2'd1:    bus.readdata = status;
            2'd2:    bus.readdata = {31'b0, enable_q};
            2'd3:    bus.readdata = tx_count_q;
            default: bus.readdata = '0;
        endcase
    end

    assign bus.hw_ready  = hw_ready;
    assign bus.net_valid = net_valid_q;
    assign bus.net_data  = net_data_q;

endmodule
`default_nettype wire

// File: tb/tb_debug_net_inject_ctrl.sv
`default_nettype none
// ==========================================================================
// tb_debug_net_inject_ctrl : randomized bench with a queue-based reference
// Revision : 1.0
// ==========================================================================
module tb_debug_net_inject_ctrl;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    debug_net_inject_ctrl_if bus();

    debug_net_inject_ctrl #(.FIFO_DEPTH(DEPTH), .CNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: what the host and network should see, held as a queue.
    logic [31:0] m_fifo[$];
    bit          m_en, m_ovf, m_valid, m_last;
    logic [31:0] m_data, m_tx;
    logic [31:0] exp_q[$], obs_q[$];
    int          hr_obs, hr_exp, out_diff;
    bit          last_hwr, hw_once;

    function automatic logic [31:0] m_status();
        logic [31:0] s = '0;
        s[0]     = (m_fifo.size() == 0);
        s[1]     = (m_fifo.size() == DEPTH);
        s[2]     = m_ovf;
        s[3]     = m_valid;
        s[4]     = m_last;
        s[15:8]  = 8'(m_fifo.size());
        s[16]    = m_en;
        return s;
    endfunction

    task automatic model_reset();
        m_fifo.delete(); exp_q.delete(); obs_q.delete();
        m_en = 0; m_ovf = 0; m_valid = 0; m_last = 1; m_data = '0; m_tx = '0;
        hr_obs = 0; hr_exp = 0; out_diff = 0; last_hwr = 0; hw_once = 0;
    endtask

    // One clock: sample at the current inputs, advance the model, cross the edge.
    task automatic step();
        bit wr, dwr, cwr, fl, clr, ld, ra, rb, wb, hwr;
        int pre;
        #1;
        wr  = bus.chipselect && !bus.write_n;
        dwr = wr && (bus.address == 2'd0);
        cwr = wr && (bus.address == 2'd2);
        fl  = cwr && bus.writedata[1];
        clr = cwr && bus.writedata[2];
        ld  = m_en && (!m_valid || bus.net_ready);
        pre = m_fifo.size();
        ra  = (pre != 0) && !fl;
        rb  = bus.hw_valid;
        wb  = rb && (!ra || !m_last);
        hwr = ld && wb;
        if (bus.hw_ready) hr_obs++;
        if (hwr) hr_exp++;
        if (bus.hw_ready !== hwr) out_diff++;
        last_hwr = hwr;
        if (bus.net_valid && bus.net_ready) obs_q.push_back(bus.net_data);
        if (m_valid && bus.net_ready) begin
            exp_q.push_back(m_data);
            m_tx = m_tx + 32'd1;
        end
        if (ld && (ra || rb)) begin
            m_data  = wb ? bus.hw_data : m_fifo.pop_front();
            m_valid = 1;
            m_last  = wb;
        end else if (ld && bus.net_ready) begin
            m_valid = 0;
        end
        if (clr) m_ovf = 0;
        if (fl) m_fifo.delete();
        else if (dwr) begin
            if (pre < DEPTH) m_fifo.push_back(bus.writedata);
            else m_ovf = 1;
        end
        if (cwr) m_en = bus.writedata[0];
        @(posedge clk);
        #1;
        if (bus.net_valid !== m_valid || (m_valid && bus.net_data !== m_data)) out_diff++;
        @(negedge clk);
        bus.chipselect = 0;
        bus.write_n    = 1;
        if (hw_once && hwr) bus.hw_valid = 0;
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
        bus.chipselect = 1; bus.write_n = 0; bus.address = a; bus.writedata = d;
        step();
    endtask

    task automatic peek(input logic [1:0] a, output logic [31:0] d);
        bus.address = a;
        #1 d = bus.readdata;
    endtask

    task automatic do_reset();
        reset_n = 0;
        bus.chipselect = 0; bus.write_n = 1; bus.address = 0; bus.writedata = 0;
        bus.hw_valid = 0; bus.hw_data = 0; bus.net_ready = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1;
    endtask

    task automatic test_reset();
        logic [31:0] r;
        do_reset();
        bus.hw_valid = 1;
        #1;
        checks++; if (bus.net_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.net_valid); end
        checks++; if (bus.net_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", bus.net_data); end
        checks++; if (bus.hw_ready !== 1'b0) begin errors++; $display("FAIL reset_hw_ready: got %b expected 0", bus.hw_ready); end
        peek(2'd1, r);
        checks++; if (r !== 32'h0000_0011) begin errors++; $display("FAIL reset_status: got %h expected 00000011", r); end
        peek(2'd2, r);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL reset_ctrl: got %h expected 0", r); end
        peek(2'd3, r);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL reset_tx: got %h expected 0", r); end
        bus.hw_valid = 0;
        @(negedge clk);
    endtask

    task automatic test_latency();
        logic [31:0] r;
        bus.net_ready = 1;
        wr_reg(2'd2, 32'h1);
        wr_reg(2'd0, 32'hA5A5_0001);
        checks++; if (bus.net_valid !== 1'b0) begin errors++; $display("FAIL lat_edge1: got %b expected 0", bus.net_valid); end
        step();
        checks++; if (bus.net_valid !== 1'b1 || bus.net_data !== 32'hA5A5_0001) begin errors++; $display("FAIL lat_edge2: got %b/%h expected 1/a5a50001", bus.net_valid, bus.net_data); end
        step();
        peek(2'd3, r);
        checks++; if (r !== 32'd1) begin errors++; $display("FAIL lat_tx: got %0d expected 1", r); end
        peek(2'd1, r);
        checks++; if (r[0] !== 1'b1 || r !== m_status()) begin errors++; $display("FAIL lat_status: got %h expected %h", r, m_status()); end
    endtask

    task automatic test_arbitration();
        logic [31:0] r;
        logic [31:0] want[3];
        bit          grants[3];
        bit          ok;
        do_reset();
        wr_reg(2'd0, 32'h11);
        wr_reg(2'd0, 32'h22);
        bus.hw_valid = 1; bus.hw_data = 32'hB0; bus.net_ready = 1; hw_once = 1;
        wr_reg(2'd2, 32'h1);
        for (int i = 0; i < 3; i++) begin
            step();
            peek(2'd1, r);
            grants[i] = r[4];
        end
        step(); step();
        hw_once = 0;
        checks++; if (grants[0] !== 1'b0 || grants[1] !== 1'b1 || grants[2] !== 1'b0)
            begin errors++; $display("FAIL arb_grants: got %b%b%b expected 010", grants[0], grants[1], grants[2]); end
        want[0] = 32'h11; want[1] = 32'hB0; want[2] = 32'h22;
        ok = (obs_q.size() == 3);
        for (int i = 0; i < 3 && ok; i++) if (obs_q[i] !== want[i]) ok = 0;
        checks++; if (!ok) begin errors++; $display("FAIL arb_stream: got %0d words expected 11,b0,22", obs_q.size()); end
        checks++; if (hr_obs !== 1) begin errors++; $display("FAIL arb_hw_ready: got %0d pulses expected 1", hr_obs); end
    endtask

    task automatic test_overflow();
        logic [31:0] w[9];
        logic [31:0] r;
        bit          ok;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            w[i] = $urandom;
            wr_reg(2'd0, w[i]);
        end
        peek(2'd1, r);
        checks++; if (r[15:8] !== 8'd8 || r[1] !== 1'b1 || r[2] !== 1'b1 || r !== m_status())
            begin errors++; $display("FAIL ovf_status: got %h expected %h", r, m_status()); end
        bus.net_ready = 1;
        wr_reg(2'd2, 32'h5);
        for (int i = 0; i < 10; i++) step();
        ok = (obs_q.size() == 8);
        for (int i = 0; i < 8 && ok; i++) if (obs_q[i] !== w[i]) ok = 0;
        checks++; if (!ok) begin errors++; $display("FAIL ovf_drain: got %0d words expected first 8 in order", obs_q.size()); end
        peek(2'd1, r);
        checks++; if (r[2] !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", r[2]); end
    endtask

    task automatic test_backpressure();
        logic [31:0] a, b, r;
        bit          stable;
        do_reset();
        a = $urandom; b = $urandom;
        wr_reg(2'd2, 32'h1);
        wr_reg(2'd0, a);
        wr_reg(2'd0, b);
        bus.hw_valid = 1; bus.hw_data = $urandom;
        stable = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            peek(2'd1, r);
            if (bus.net_valid !== 1'b1 || bus.net_data !== a || r[15:8] !== 8'd1) stable = 0;
        end
        checks++; if (!stable) begin errors++; $display("FAIL bp_stable: got %b/%h expected 1/%h", bus.net_valid, bus.net_data, a); end
        checks++; if (hr_obs !== 0) begin errors++; $display("FAIL bp_hw_ready: got %0d pulses expected 0", hr_obs); end
        bus.net_ready = 1;
        hw_once = 1;
        step();
        checks++; if (bus.net_valid !== 1'b1 || bus.net_data !== m_data || obs_q.size() != 1)
            begin errors++; $display("FAIL bp_next: got %h expected %h", bus.net_data, m_data); end
        for (int i = 0; i < 4; i++) step();
        hw_once = 0;
        checks++; if (out_diff !== 0) begin errors++; $display("FAIL bp_cycles: got %0d diffs expected 0", out_diff); end
    endtask

    task automatic test_flush();
        logic [31:0] w0, r;
        do_reset();
        wr_reg(2'd2, 32'h1);
        w0 = $urandom;
        wr_reg(2'd0, w0);
        for (int i = 0; i < 3; i++) wr_reg(2'd0, $urandom);
        peek(2'd1, r);
        checks++; if (r[15:8] !== 8'd3) begin errors++; $display("FAIL flush_pre: got %0d expected 3", r[15:8]); end
        wr_reg(2'd2, 32'h3);
        peek(2'd1, r);
        checks++; if (r[15:8] !== 8'd0 || r[2] !== 1'b0 || r[0] !== 1'b1)
            begin errors++; $display("FAIL flush_status: got %h expected %h", r, m_status()); end
        checks++; if (bus.net_valid !== 1'b1 || bus.net_data !== w0)
            begin errors++; $display("FAIL flush_inflight: got %b/%h expected 1/%h", bus.net_valid, bus.net_data, w0); end
        bus.net_ready = 1;
        step(); step();
        checks++; if (obs_q.size() != 1 || obs_q[0] !== w0 || bus.net_valid !== 1'b0)
            begin errors++; $display("FAIL flush_drain: got %0d words expected 1", obs_q.size()); end
    endtask

    task automatic test_random();
        logic [31:0] r;
        int          sdiff;
        bit          ok;
        do_reset();
        wr_reg(2'd2, 32'h1);
        sdiff = 0;
        for (int i = 0; i < 600; i++) begin
            int op;
            bus.net_ready = ($urandom_range(0, 3) != 0);
            if (!bus.hw_valid || last_hwr) begin
                bus.hw_valid = ($urandom_range(0, 2) == 0);
                bus.hw_data  = $urandom;
            end
            op = $urandom_range(0, 31);
            if (op < 10) begin
                bus.chipselect = 1; bus.write_n = 0; bus.address = 2'd0; bus.writedata = $urandom;
            end else if (op == 10) begin
                bus.chipselect = 1; bus.write_n = 0; bus.address = 2'd2;
                bus.writedata = {29'b0, 3'($urandom_range(0, 7))};
            end else if (op < 14) begin
                bus.chipselect = 1; bus.write_n = 0; bus.address = 2'd2; bus.writedata = 32'h1;
            end else begin
                peek(2'd1, r);
                if (r !== m_status()) sdiff++;
            end
            step();
        end
        checks++; if (sdiff !== 0) begin errors++; $display("FAIL rnd_status: got %0d diffs expected 0", sdiff); end
        checks++; if (out_diff !== 0) begin errors++; $display("FAIL rnd_outputs: got %0d diffs expected 0", out_diff); end
        ok = (obs_q.size() == exp_q.size());
        for (int i = 0; i < obs_q.size() && ok; i++) if (obs_q[i] !== exp_q[i]) ok = 0;
        checks++; if (!ok) begin errors++; $display("FAIL rnd_stream: got %0d words expected %0d", obs_q.size(), exp_q.size()); end
        peek(2'd3, r);
        checks++; if (r !== m_tx) begin errors++; $display("FAIL rnd_tx: got %0d expected %0d", r, m_tx); end
    endtask

    task automatic test_reset_midstream();
        logic [31:0] r;
        bus.net_ready = 1; bus.hw_valid = 1; bus.hw_data = $urandom;
        wr_reg(2'd2, 32'h1);
        step(); step();
        checks++; if (bus.net_valid !== 1'b1) begin errors++; $display("FAIL mid_pre: got %b expected 1", bus.net_valid); end
        #2 reset_n = 0;
        #1;
        checks++; if (bus.net_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b expected 0", bus.net_valid); end
        peek(2'd1, r);
        checks++; if (r[15:8] !== 8'd0 || r[16] !== 1'b0) begin errors++; $display("FAIL mid_status: got %h expected count 0 enable 0", r); end
        peek(2'd3, r);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL mid_tx: got %h expected 0", r); end
        model_reset();
        @(negedge clk);
        reset_n = 1;
        for (int i = 0; i < 5; i++) step();
        checks++; if (bus.net_valid !== 1'b0 || hr_obs !== 0 || out_diff !== 0)
            begin errors++; $display("FAIL mid_idle: got valid %b hw_ready %0d expected 0/0", bus.net_valid, hr_obs); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_arbitration();
        test_overflow();
        test_backpressure();
        test_flush();
        test_random();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
`default_nettype wire
